// File: rtl/pc3_pkg.sv
// Shared definitions for the PC3 multicycle control unit: opcodes, FSM states,
// ALU operation codes and datapath mux select codes.
package pc3_pkg;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        PARADO     = 3'd5
    } estado_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JMP  = 6'b000010;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] ULA_ADD = 4'b0000;
    localparam logic [3:0] ULA_SUB = 4'b0001;
    localparam logic [3:0] ULA_AND = 4'b0010;
    localparam logic [3:0] ULA_OR  = 4'b0011;
    localparam logic [3:0] ULA_SLT = 4'b0100;

    localparam logic [1:0] EXT_ARIT   = 2'b00;
    localparam logic [1:0] EXT_SALTO  = 2'b01;
    localparam logic [1:0] EXT_DESLOC = 2'b10;

    localparam logic [1:0] PCF_MAIS4  = 2'b00;
    localparam logic [1:0] PCF_DESVIO = 2'b01;
    localparam logic [1:0] PCF_SALTO  = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_CONST4 = 2'b01;
    localparam logic [1:0] SRCB_IMED   = 2'b10;

    // R-type funct field to ALU operation; unknown functs fall back to add.
    function automatic logic [3:0] ula_op_funct(input logic [5:0] funct);
        case (funct)
            FUNCT_ADD: return ULA_ADD;
            FUNCT_SUB: return ULA_SUB;
            FUNCT_AND: return ULA_AND;
            FUNCT_OR:  return ULA_OR;
            FUNCT_SLT: return ULA_SLT;
            default:   return ULA_ADD;
        endcase
    endfunction

    function automatic logic opcode_valido(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_contador_espera.sv
// Memory wait counter: cleared on entry to an access state, counts cycles
// without mem_pronto and flags estouro when the count reaches ESPERA_MAX.
module contador_espera #(
    parameter int unsigned ESPERA_MAX = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic limpa,
    input  logic habilita,
    output logic estouro
);

    localparam logic [15:0] LIMITE = 16'(ESPERA_MAX);

    logic [15:0] conta_q, conta_d;

    // Next count: clear has priority over counting.
    always_comb begin
        conta_d = conta_q;
        if (limpa) begin
            conta_d = '0;
        end else if (habilita) begin
            conta_d = conta_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conta_q <= '0;
        end else begin
            conta_q <= conta_d;
        end
    end

    assign estouro = (conta_q == LIMITE);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the PC3 datapath (fetch/decode/execute/memory/
// writeback). Optional retired-instruction counter enabled by the macro
// PC3_CONTADOR_INSTR_EN, which adds the instr_retiradas port.
module unidade_controle_multiciclo
    import pc3_pkg::*;
#(
    parameter int unsigned ESPERA_MAX = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instrucao,
    input  logic        mem_pronto,
    input  logic        ula_zero,
    output logic        pc_escreve,
    output logic [1:0]  pc_fonte,
    output logic        ir_escreve,
    output logic        mem_le,
    output logic        mem_escreve,
    output logic        mem_end_sel,
    output logic        reg_escreve,
    output logic        reg_dado_sel,
    output logic [1:0]  ula_src_b,
    output logic [3:0]  ula_op,
    output logic [1:0]  ext_selecao,
    output logic        parado,
    output logic        falha,
    output logic [2:0]  estado
`ifdef PC3_CONTADOR_INSTR_EN
    ,
    output logic [31:0] instr_retiradas
`endif
);

    estado_t     estado_q, estado_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [1:0]  ext_selecao_q, ext_selecao_d;
    logic        falha_q, falha_d;
    logic        estouro, cont_limpa, cont_habilita;
    logic [5:0]  op_ir, funct_ir;
    logic        unused_instr;

    assign op_ir        = instrucao[31:26];
    assign funct_ir     = instrucao[5:0];
    assign unused_instr = ^instrucao[25:6];

    // The wait counter restarts on every entry to an access state and only
    // advances while an access is outstanding.
    assign cont_limpa    = ((estado_d == BUSCA) || (estado_d == MEMORIA)) && (estado_d != estado_q);
    assign cont_habilita = ((estado_q == BUSCA) || (estado_q == MEMORIA)) && !mem_pronto;

    contador_espera #(.ESPERA_MAX(ESPERA_MAX)) u_contador_espera (
        .clock    (clock),
        .reset_n  (reset_n),
        .limpa    (cont_limpa),
        .habilita (cont_habilita),
        .estouro  (estouro)
    );

    // Next state, opcode latch, extender select and sticky fault.
    always_comb begin
        estado_d      = estado_q;
        opcode_d      = opcode_q;
        ext_selecao_d = ext_selecao_q;
        falha_d       = falha_q;
        case (estado_q)
            BUSCA: begin
                if (mem_pronto) begin
                    estado_d = DECODIFICA;
                end else if (estouro) begin
                    falha_d  = 1'b1;
                    estado_d = PARADO;
                end
            end
            DECODIFICA: begin
                opcode_d = op_ir;
                case (op_ir)
                    OP_ADDI: begin
                        ext_selecao_d = EXT_ARIT;
                        estado_d      = EXECUTA;
                    end
                    OP_LW, OP_SW, OP_BEQ: begin
                        ext_selecao_d = EXT_DESLOC;
                        estado_d      = EXECUTA;
                    end
                    OP_R:    estado_d = EXECUTA;
                    OP_JMP: begin
                        ext_selecao_d = EXT_SALTO;
                        estado_d      = BUSCA;
                    end
                    OP_HLT:  estado_d = PARADO;
                    default: begin
                        falha_d  = 1'b1;
                        estado_d = BUSCA;
                    end
                endcase
            end
            EXECUTA: begin
                case (opcode_q)
                    OP_BEQ:       estado_d = BUSCA;
                    OP_LW, OP_SW: estado_d = MEMORIA;
                    default:      estado_d = ESCRITA;
                endcase
            end
            MEMORIA: begin
                if (mem_pronto) begin
                    estado_d = (opcode_q == OP_LW) ? ESCRITA : BUSCA;
                end else if (estouro) begin
                    falha_d  = 1'b1;
                    estado_d = PARADO;
                end
            end
            ESCRITA: estado_d = BUSCA;
            PARADO:  estado_d = PARADO;
            default: estado_d = BUSCA;
        endcase
    end

    // Datapath controls from the current state; all forced low while reset
    // is asserted so an interrupted access is dropped at once.
    always_comb begin
        pc_escreve   = 1'b0;
        pc_fonte     = PCF_MAIS4;
        ir_escreve   = 1'b0;
        mem_le       = 1'b0;
        mem_escreve  = 1'b0;
        mem_end_sel  = 1'b0;
        reg_escreve  = 1'b0;
        reg_dado_sel = 1'b0;
        ula_src_b    = SRCB_REG;
        ula_op       = ULA_ADD;
        if (reset_n) begin
            case (estado_q)
                BUSCA: begin
                    mem_le = !(estouro && !mem_pronto);
                    if (mem_pronto) begin
                        ir_escreve = 1'b1;
                        pc_escreve = 1'b1;
                    end
                end
                DECODIFICA: begin
                    if (op_ir == OP_JMP) begin
                        pc_escreve = 1'b1;
                        pc_fonte   = PCF_SALTO;
                    end
                end
                EXECUTA: begin
                    case (opcode_q)
                        OP_R: begin
                            ula_src_b = SRCB_REG;
                            ula_op    = ula_op_funct(funct_ir);
                        end
                        OP_BEQ: begin
                            ula_src_b = SRCB_REG;
                            ula_op    = ULA_SUB;
                            if (ula_zero) begin
                                pc_escreve = 1'b1;
                                pc_fonte   = PCF_DESVIO;
                            end
                        end
                        default: ula_src_b = SRCB_IMED;
                    endcase
                end
                MEMORIA: begin
                    mem_end_sel = 1'b1;
                    if (opcode_q == OP_LW) begin
                        mem_le = !(estouro && !mem_pronto);
                    end else begin
                        mem_escreve = !(estouro && !mem_pronto);
                    end
                end
                ESCRITA: begin
                    reg_escreve  = 1'b1;
                    reg_dado_sel = (opcode_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

`ifdef PC3_CONTADOR_INSTR_EN
    logic [31:0] retiradas_q, retiradas_d;
    logic        conclui;

    // An instruction retires when control returns to BUSCA, except when the
    // return was caused by an invalid opcode.
    always_comb begin
        conclui     = (estado_d == BUSCA) && (estado_q != BUSCA) &&
                      !((estado_q == DECODIFICA) && !opcode_valido(op_ir));
        retiradas_d = retiradas_q + {31'd0, conclui};
    end

    assign instr_retiradas = retiradas_q;
`endif

    // FSM state and registered status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q      <= BUSCA;
            opcode_q      <= OP_R;
            ext_selecao_q <= EXT_ARIT;
            falha_q       <= 1'b0;
`ifdef PC3_CONTADOR_INSTR_EN
            retiradas_q   <= '0;
`endif
        end else begin
            estado_q      <= estado_d;
            opcode_q      <= opcode_d;
            ext_selecao_q <= ext_selecao_d;
            falha_q       <= falha_d;
`ifdef PC3_CONTADOR_INSTR_EN
            retiradas_q   <= retiradas_d;
`endif
        end
    end

    assign ext_selecao = ext_selecao_q;
    assign falha       = falha_q;
    assign parado      = (estado_q == PARADO);
    assign estado      = estado_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo. Per-cycle stimulus and
// expected output snapshots are queued per scenario and compared cycle by cycle.
module tb_unidade_controle_multiciclo;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instrucao = 32'd0;
    logic        mem_pronto = 1'b0;
    logic        ula_zero = 1'b0;
    logic        pc_escreve, ir_escreve, mem_le, mem_escreve, mem_end_sel;
    logic        reg_escreve, reg_dado_sel, parado, falha;
    logic [1:0]  pc_fonte, ula_src_b, ext_selecao;
    logic [3:0]  ula_op;
    logic [2:0]  estado;
`ifdef PC3_CONTADOR_INSTR_EN
    logic [31:0] instr_retiradas;
`endif

    localparam logic [31:0] I_ADDI = 32'h2000_0005;
    localparam logic [31:0] I_LW   = 32'h8C00_0004;
    localparam logic [31:0] I_SW   = 32'hAC00_0008;
    localparam logic [31:0] I_BEQ  = 32'h1000_0003;
    localparam logic [31:0] I_JMP  = 32'h0800_0010;
    localparam logic [31:0] I_HLT  = 32'hFC00_0000;
    localparam logic [31:0] I_INV  = 32'hF800_0000;
    localparam logic [31:0] I_SUB  = 32'h0000_0022;
    localparam logic [31:0] I_SLT  = 32'h0000_002A;

    always #5 clock = ~clock;

    unidade_controle_multiciclo #(.ESPERA_MAX(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instrucao    (instrucao),
        .mem_pronto   (mem_pronto),
        .ula_zero     (ula_zero),
        .pc_escreve   (pc_escreve),
        .pc_fonte     (pc_fonte),
        .ir_escreve   (ir_escreve),
        .mem_le       (mem_le),
        .mem_escreve  (mem_escreve),
        .mem_end_sel  (mem_end_sel),
        .reg_escreve  (reg_escreve),
        .reg_dado_sel (reg_dado_sel),
        .ula_src_b    (ula_src_b),
        .ula_op       (ula_op),
        .ext_selecao  (ext_selecao),
        .parado       (parado),
        .falha        (falha),
        .estado       (estado)
`ifdef PC3_CONTADOR_INSTR_EN
        ,
        .instr_retiradas (instr_retiradas)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        pronto;
        logic        zero;
    } stim_t;

    stim_t       stim_q[$];
    logic [21:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    // Snapshot layout: estado, pcw, pcf, irw, mle, mesc, mend, rw, rds, srcb, op, ext, parado, falha
    function automatic logic [21:0] ev(input logic [2:0] st, input logic pcw, input logic [1:0] pcf,
                                       input logic irw, input logic mle, input logic mesc,
                                       input logic mend, input logic rw, input logic rds,
                                       input logic [1:0] srcb, input logic [3:0] op,
                                       input logic [1:0] ext, input logic par, input logic fal);
        return {st, pcw, pcf, irw, mle, mesc, mend, rw, rds, srcb, op, ext, par, fal};
    endfunction

    function automatic logic [21:0] busca_ok(input logic [1:0] ext, input logic fal);
        return ev(3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, ext, 1'b0, fal);
    endfunction

    function automatic logic [21:0] ocioso(input logic [2:0] st, input logic [1:0] ext, input logic fal);
        return ev(st, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, ext, 1'b0, fal);
    endfunction

    function automatic logic [21:0] obs();
        return {estado, pc_escreve, pc_fonte, ir_escreve, mem_le, mem_escreve, mem_end_sel,
                reg_escreve, reg_dado_sel, ula_src_b, ula_op, ext_selecao, parado, falha};
    endfunction

    task automatic push(input logic [31:0] i, input logic p, input logic z, input logic [21:0] e);
        stim_t s;
        s.instr = i; s.pronto = p; s.zero = z;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; instrucao = 32'd0; mem_pronto = 1'b0; ula_zero = 1'b0;
        #12;
        checks++;
        if (obs() !== 22'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), 22'd0);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs() !== ev(3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0)) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs(),
                     ev(3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0));
        end
    endtask

    task automatic test_jmp();
        stim_t s; logic [21:0] e; int n = 0;
        push(I_JMP, 1, 0, busca_ok(2'b00, 0));
        push(I_JMP, 1, 0, ev(3'd1, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL jmp c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_addi();
        stim_t s; logic [21:0] e; int n = 0;
        push(I_ADDI, 1, 0, busca_ok(2'b01, 0));
        push(I_ADDI, 1, 0, ocioso(3'd1, 2'b01, 0));
        push(I_ADDI, 1, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 4'd0, 2'b00, 0, 0));
        push(I_ADDI, 1, 0, ev(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 4'd0, 2'b00, 0, 0));
        push(I_ADDI, 1, 0, busca_ok(2'b00, 0));
        push(I_ADDI, 1, 0, ocioso(3'd1, 2'b00, 0));
        push(I_ADDI, 1, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 4'd0, 2'b00, 0, 0));
        push(I_ADDI, 1, 0, ev(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 4'd0, 2'b00, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL addi c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_lw_sw();
        stim_t s; logic [21:0] e; int n = 0;
        push(I_LW, 1, 0, busca_ok(2'b00, 0));
        push(I_LW, 0, 0, ocioso(3'd1, 2'b00, 0));
        push(I_LW, 0, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 4'd0, 2'b10, 0, 0));
        for (int k = 0; k < 4; k++)
            push(I_LW, (k == 3), 0, ev(3'd3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0, 2'b10, 0, 0));
        push(I_LW, 0, 0, ev(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00, 4'd0, 2'b10, 0, 0));
        push(I_SW, 1, 0, busca_ok(2'b10, 0));
        push(I_SW, 1, 0, ocioso(3'd1, 2'b10, 0));
        push(I_SW, 1, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 4'd0, 2'b10, 0, 0));
        push(I_SW, 1, 0, ev(3'd3, 0, 2'b00, 0, 0, 1, 1, 0, 0, 2'b00, 4'd0, 2'b10, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL lw_sw c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_beq();
        stim_t s; logic [21:0] e; int n = 0;
        for (int z = 1; z >= 0; z--) begin
            push(I_BEQ, 1, 1'(z), busca_ok(2'b10, 0));
            push(I_BEQ, 1, 1'(z), ocioso(3'd1, 2'b10, 0));
            push(I_BEQ, 1, 1'(z), ev(3'd2, 1'(z), (z == 1) ? 2'b01 : 2'b00, 0, 0, 0, 0, 0, 0,
                                     2'b00, 4'b0001, 2'b10, 0, 0));
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL beq c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_rtype();
        stim_t s; logic [21:0] e; int n = 0;
        push(I_SUB, 1, 0, busca_ok(2'b10, 0));
        push(I_SUB, 1, 0, ocioso(3'd1, 2'b10, 0));
        push(I_SUB, 1, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 2'b10, 0, 0));
        push(I_SUB, 1, 0, ev(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 4'd0, 2'b10, 0, 0));
        push(I_SLT, 1, 0, busca_ok(2'b10, 0));
        push(I_SLT, 1, 0, ocioso(3'd1, 2'b10, 0));
        push(I_SLT, 1, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0100, 2'b10, 0, 0));
        push(I_SLT, 1, 0, ev(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 4'd0, 2'b10, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL rtype c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_invalid();
        stim_t s; logic [21:0] e; int n = 0;
        push(I_INV, 1, 0, busca_ok(2'b10, 0));
        push(I_INV, 1, 0, ocioso(3'd1, 2'b10, 0));
        push(I_ADDI, 1, 0, busca_ok(2'b10, 1));
        push(I_ADDI, 1, 0, ocioso(3'd1, 2'b10, 1));
        push(I_ADDI, 1, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 4'd0, 2'b00, 0, 1));
        push(I_ADDI, 1, 0, ev(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 4'd0, 2'b00, 0, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL invalid c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_hlt();
        stim_t s; logic [21:0] e; int n = 0;
        push(I_HLT, 1, 0, busca_ok(2'b00, 1));
        push(I_HLT, 1, 0, ocioso(3'd1, 2'b00, 1));
        push(I_HLT, 1, 0, ev(3'd5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 1));
        push(I_JMP, 1, 1, ev(3'd5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL hlt c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t s; logic [21:0] e; int n = 0;
        reset_n = 1'b0; mem_pronto = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++)
            push(I_ADDI, 0, 0, ev(3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0));
        push(I_ADDI, 0, 0, ocioso(3'd0, 2'b00, 0));
        push(I_ADDI, 0, 0, ev(3'd5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 1));
        push(I_ADDI, 1, 0, ev(3'd5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL timeout c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid_access();
        stim_t s; logic [21:0] e; int n = 0;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        push(I_LW, 1, 0, busca_ok(2'b00, 0));
        push(I_LW, 0, 0, ocioso(3'd1, 2'b00, 0));
        push(I_LW, 0, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 4'd0, 2'b10, 0, 0));
        push(I_LW, 0, 0, ev(3'd3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0, 2'b10, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL mid_reset c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
        e = ev(3'd3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0, 2'b10, 0, 0);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL mid_reset_pre got=%h exp=%h", obs(), e); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 22'd0) begin failures++; $display("FAIL mid_reset_async got=%h exp=%h", obs(), 22'd0); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        n = 0;
        push(I_ADDI, 1, 0, busca_ok(2'b00, 0));
        push(I_ADDI, 1, 0, ocioso(3'd1, 2'b00, 0));
        push(I_ADDI, 1, 0, ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 4'd0, 2'b00, 0, 0));
        push(I_ADDI, 1, 0, ev(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 4'd0, 2'b00, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); instrucao = s.instr; mem_pronto = s.pronto; ula_zero = s.zero;
            @(negedge clock);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL post_reset c%0d got=%h exp=%h", n, obs(), e); end
            n++;
            @(posedge clock); #1;
        end
`ifdef PC3_CONTADOR_INSTR_EN
        checks++;
        if (instr_retiradas !== 32'd1) begin
            failures++;
            $display("FAIL instr_retiradas got=%0d exp=%0d", instr_retiradas, 1);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_jmp();
        test_addi();
        test_lw_sw();
        test_beq();
        test_rtype();
        test_invalid();
        test_hlt();
        test_timeout();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
